cmd_capture_buffer: RTL

- Passive monitor on the DUV request port: reconstructs each command into a packet of tag, command, operand 1 and operand 2.
- Stamps each packet with the cycle count of its command cycle and buffers packets in a DEPTH-entry FIFO.
- Hands packets to the golden model / scoreboard over a valid/ready interface.
- Reports overflow and protocol errors instead of silently dropping or overwriting packets.

---
 rtl/cmd_capture_buffer_pkg.sv | 42 ++++
 rtl/cmd_capture_buffer_if.sv | 32 +++
 rtl/cmd_capture_buffer_sync_fifo.sv | 69 ++++++
 rtl/cmd_capture_buffer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/cmd_capture_buffer_pkg.sv
// Shared types and packet-layout helpers for the command capture buffer.
package cmd_capture_pkg;

  // Capture FSM: IDLE waits for a command cycle, OP2 takes the second operand.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OP2  = 1'b1
  } cap_state_e;

  // Field layout at the default widths: {tag, cmd, op1, op2}, op2 in the LSBs.
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CMD_W  = 4;
  localparam int DEF_TAG_W  = 2;
  localparam int DEF_PKT_W  = DEF_TAG_W + DEF_CMD_W + 2 * DEF_DATA_W;
  localparam int OP2_LSB    = 0;
  localparam int OP1_LSB    = DEF_DATA_W;
  localparam int CMD_LSB    = 2 * DEF_DATA_W;
  localparam int TAG_LSB    = CMD_LSB + DEF_CMD_W;

  // Widest field / packet the helper can build; callers truncate to their size.
  localparam int FIELD_MAX_W = 64;
  localparam int PKT_MAX_W   = 4 * FIELD_MAX_W;

  // Pack {tag, cmd, op1, op2} for arbitrary cmd/data widths. Fields must be
  // zero-extended by the caller; the result is right-aligned.
  function automatic logic [PKT_MAX_W-1:0] pack_pkt(
    input logic [FIELD_MAX_W-1:0] tag,
    input logic [FIELD_MAX_W-1:0] cmd,
    input logic [FIELD_MAX_W-1:0] op1,
    input logic [FIELD_MAX_W-1:0] op2,
    input int                     cmd_w,
    input int                     data_w
  );
    logic [PKT_MAX_W-1:0] p;
    p = (PKT_MAX_W'(tag) << (cmd_w + 2 * data_w))
      | (PKT_MAX_W'(cmd) << (2 * data_w))
      | (PKT_MAX_W'(op1) << data_w)
      |  PKT_MAX_W'(op2);
    return p;
  endfunction

endpackage

// File: rtl/cmd_capture_buffer_if.sv
// Sniffed request port plus the packet valid/ready stream to the consumer.
// Handshake: a packet transfers on a rising edge where pkt_valid && pkt_ready;
// while pkt_valid && !pkt_ready, pkt_out/pkt_ts are held stable, and
// pkt_valid never drops without a transfer.
interface cmd_capture_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int TAG_W  = 2,
  parameter int TS_W   = 32
);
  localparam int PKT_W = TAG_W + CMD_W + 2 * DATA_W;

  logic [CMD_W-1:0]  req_cmd_in;
  logic [DATA_W-1:0] req_data_in;
  logic [TAG_W-1:0]  req_tag_in;
  logic              pkt_valid;
  logic              pkt_ready;
  logic [PKT_W-1:0]  pkt_out;
  logic [TS_W-1:0]   pkt_ts;

  // master: the capture buffer (monitors requests, produces packets)
  modport master (
    input  req_cmd_in, req_data_in, req_tag_in, pkt_ready,
    output pkt_valid, pkt_out, pkt_ts
  );

  // slave: the request source / packet consumer side
  modport slave (
    output req_cmd_in, req_data_in, req_tag_in, pkt_ready,
    input  pkt_valid, pkt_out, pkt_ts
  );
endinterface

// File: rtl/cmd_capture_buffer_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data, full/empty/level.
// A write on a full FIFO is accepted only when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap modulo DEPTH) and level.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    do_pop   = rd_en && !empty;
    do_push  = wr_en && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Register FIFO state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/cmd_capture_buffer.sv
// Passive request-port monitor: rebuilds commands into {tag, cmd, op1, op2}
// packets, timestamps them with the command-cycle count and queues them for
// the scoreboard. Drops and protocol violations are reported, never hidden.
module cmd_capture_buffer
  import cmd_capture_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int TAG_W  = 2,
  parameter int TS_W   = 32,
  parameter int DEPTH  = 4,
  parameter int TWO_OP = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  cmd_capture_buffer_if.master   bus,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overflow,
  output logic [7:0]             drop_count,
  output logic                   proto_err,
  output cap_state_e             capture_state
);
  localparam int PKT_W  = TAG_W + CMD_W + 2 * DATA_W;
  localparam int FIFO_W = PKT_W + TS_W;

  cap_state_e        state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  logic [TS_W-1:0]   ts_cap_q, ts_cap_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_q, drop_d;
  logic              proto_q, proto_d;
  logic [FIFO_W-1:0] last_q, last_d;

  logic              push;
  logic [TAG_W-1:0]  push_tag;
  logic [CMD_W-1:0]  push_cmd;
  logic [DATA_W-1:0] push_op1;
  logic [DATA_W-1:0] push_op2;
  logic [TS_W-1:0]   push_ts;
  logic              proto_set;
  logic [PKT_W-1:0]  push_pkt;
  logic              pop;
  logic              drop;

  logic [FIFO_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;

  // Capture FSM next state and the packet being pushed this cycle.
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    tag_d     = tag_q;
    op1_d     = op1_q;
    ts_cap_d  = ts_cap_q;
    push      = 1'b0;
    push_tag  = tag_q;
    push_cmd  = cmd_q;
    push_op1  = op1_q;
    push_op2  = '0;
    push_ts   = ts_cap_q;
    proto_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_cmd_in != '0) begin
          cmd_d    = bus.req_cmd_in;
          tag_d    = bus.req_tag_in;
          op1_d    = bus.req_data_in;
          ts_cap_d = ts_q;
          if (TWO_OP != 0) begin
            state_d = OP2;
          end else begin
            // Single-operand: packet leaves in the command cycle itself.
            push     = 1'b1;
            push_tag = bus.req_tag_in;
            push_cmd = bus.req_cmd_in;
            push_op1 = bus.req_data_in;
            push_ts  = ts_q;
          end
        end
      end
      OP2: begin
        // This cycle is always the operand, even if a command shows up.
        push      = 1'b1;
        push_op2  = bus.req_data_in;
        proto_set = (bus.req_cmd_in != '0);
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_pkt = PKT_W'(pack_pkt(FIELD_MAX_W'(push_tag), FIELD_MAX_W'(push_cmd),
                                    FIELD_MAX_W'(push_op1), FIELD_MAX_W'(push_op2),
                                    CMD_W, DATA_W));

  // Handshake, drop accounting, sticky flags, timestamp and held output.
  always_comb begin
    pop        = bus.pkt_ready && !fifo_empty;
    drop       = push && fifo_full && !pop;
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    proto_d    = proto_q | proto_set;
    ts_d       = ts_q + TS_W'(1);
    last_d     = pop ? fifo_rd_data : last_q;
  end

  // Register capture FSM and status state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tag_q      <= '0;
      op1_q      <= '0;
      ts_cap_q   <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      proto_q    <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tag_q      <= tag_d;
      op1_q      <= op1_d;
      ts_cap_q   <= ts_cap_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
      proto_q    <= proto_d;
      last_q     <= last_d;
    end
  end

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({push_pkt, push_ts}),
    .rd_en   (bus.pkt_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // When empty, the last delivered packet stays on the outputs.
  assign bus.pkt_valid = !fifo_empty;
  assign bus.pkt_out   = fifo_empty ? last_q[FIFO_W-1:TS_W] : fifo_rd_data[FIFO_W-1:TS_W];
  assign bus.pkt_ts    = fifo_empty ? last_q[TS_W-1:0]      : fifo_rd_data[TS_W-1:0];

  assign overflow      = overflow_q;
  assign drop_count    = drop_q;
  assign proto_err     = proto_q;
  assign capture_state = state_q;
endmodule
